// File: rtl/dbg_ctl.sv
// Debug run-control sequencer: gates the pipeline enable for pass-through, halt,
// fixed-length stepping, or run-until-N-events, with status counters for firmware.
module dbg_ctl #(
    parameter int CNT_BW = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cfg_valid_i,
    input  logic [1:0]        cfg_op_i,
    input  logic [1:0]        cfg_sel_i,
    input  logic [CNT_BW-1:0] cfg_arg_i,
    input  logic              ctl_pipeline_en_i,
    input  logic              dfe_valid_i,
    input  logic              aco_valid_i,
    input  logic              aco_last_i,
    input  logic              wrd_wake_valid_i,
    input  logic              wrd_wake_i,
    output logic              ctl_pipeline_en_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic              done_o,
    output logic [CNT_BW-1:0] rem_o,
    output logic [CNT_BW-1:0] evt_cnt_o,
    output logic              wake_hit_o
);

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2,
        ST_ARM  = 2'd3
    } state_t;

    localparam logic [1:0] OP_PASS = 2'd0;
    localparam logic [1:0] OP_HALT = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_ARM  = 2'd3;

    state_t            state_q, state_d;
    logic [CNT_BW-1:0] rem_q, rem_d;
    logic [CNT_BW-1:0] evt_q, evt_d;
    logic [CNT_BW-1:0] tgt_cnt_q, tgt_cnt_d;
    logic [1:0]        tgt_sel_q, tgt_sel_d;
    logic              wake_q, wake_d;
    logic              done_q, done_d;
    logic              evt_hit;
    logic [CNT_BW:0]   evt_inc;

    function automatic logic [CNT_BW-1:0] sat_inc(input logic [CNT_BW-1:0] v);
        return (&v) ? v : v + {{(CNT_BW-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        evt_hit = 1'b0;
        case (tgt_sel_q)
            2'd0:    evt_hit = dfe_valid_i;
            2'd1:    evt_hit = aco_valid_i;
            2'd2:    evt_hit = aco_last_i;
            default: evt_hit = wrd_wake_valid_i;
        endcase
    end

    // Unsaturated count + 1 so the target compare cannot wrap.
    assign evt_inc = {1'b0, evt_q} + {{CNT_BW{1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        evt_d     = evt_q;
        tgt_cnt_d = tgt_cnt_q;
        tgt_sel_d = tgt_sel_q;
        wake_d    = wake_q | (wrd_wake_valid_i & wrd_wake_i);
        done_d    = 1'b0;

        if (cfg_valid_i) begin
            // A command always wins over completion and clears per-command status.
            evt_d  = '0;
            wake_d = 1'b0;
            rem_d  = '0;
            case (cfg_op_i)
                OP_PASS: state_d = ST_PASS;
                OP_HALT: state_d = ST_HALT;
                OP_STEP: begin
                    if (cfg_arg_i != '0) begin
                        state_d = ST_STEP;
                        rem_d   = cfg_arg_i;
                    end else begin
                        state_d = ST_HALT;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    if (cfg_arg_i != '0) begin
                        state_d   = ST_ARM;
                        tgt_sel_d = cfg_sel_i;
                        tgt_cnt_d = cfg_arg_i;
                    end else begin
                        state_d = ST_HALT;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end else begin
            case (state_q)
                ST_STEP: begin
                    rem_d = rem_q - {{(CNT_BW-1){1'b0}}, 1'b1};
                    if (rem_q == {{(CNT_BW-1){1'b0}}, 1'b1}) begin
                        state_d = ST_HALT;
                        done_d  = 1'b1;
                    end
                end
                ST_ARM: begin
                    if (evt_hit) begin
                        evt_d = sat_inc(evt_q);
                        if (evt_inc == {1'b0, tgt_cnt_q}) begin
                            state_d = ST_HALT;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_PASS;
            rem_q     <= '0;
            evt_q     <= '0;
            tgt_cnt_q <= '0;
            tgt_sel_q <= '0;
            wake_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            evt_q     <= evt_d;
            tgt_cnt_q <= tgt_cnt_d;
            tgt_sel_q <= tgt_sel_d;
            wake_q    <= wake_d;
            done_q    <= done_d;
        end
    end

    assign ctl_pipeline_en_o = (state_q != ST_HALT) & ctl_pipeline_en_i;
    assign busy_o            = (state_q == ST_STEP) | (state_q == ST_ARM);
    assign halted_o          = (state_q == ST_HALT);
    assign done_o            = done_q;
    assign rem_o             = rem_q;
    assign evt_cnt_o         = evt_q;
    assign wake_hit_o        = wake_q;

endmodule

// File: tb/tb_dbg_ctl.sv
// Bench for dbg_ctl: directed run-control scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the run-control rules.
module tb_dbg_ctl;

    localparam int W = 16;
    localparam int MAXCNT = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid;
    logic [1:0]   cfg_op;
    logic [1:0]   cfg_sel;
    logic [W-1:0] cfg_arg;
    logic         en_i;
    logic         dfe_v, aco_v, aco_l, wake_v, wake;
    logic         en_o, busy, halted, done, wake_hit;
    logic [W-1:0] rem, evt_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mode 0 running freely, 1 stopped, 2 counting cycles, 3 waiting for events
    int m_mode, m_rem, m_evt, m_tgt, m_sel;
    bit m_wake, m_done;

    always #5 clk = ~clk;

    dbg_ctl #(.CNT_BW(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_op_i(cfg_op), .cfg_sel_i(cfg_sel), .cfg_arg_i(cfg_arg),
        .ctl_pipeline_en_i(en_i),
        .dfe_valid_i(dfe_v), .aco_valid_i(aco_v), .aco_last_i(aco_l),
        .wrd_wake_valid_i(wake_v), .wrd_wake_i(wake),
        .ctl_pipeline_en_o(en_o), .busy_o(busy), .halted_o(halted), .done_o(done),
        .rem_o(rem), .evt_cnt_o(evt_cnt), .wake_hit_o(wake_hit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_evt = 0; m_tgt = 0; m_sel = 0;
        m_wake = 0; m_done = 0;
    endtask

    task automatic check_all();
        chk("en_o",     32'(en_o),     32'((m_mode != 1) && en_i));
        chk("busy",     32'(busy),     32'(m_mode >= 2));
        chk("halted",   32'(halted),   32'(m_mode == 1));
        chk("done",     32'(done),     32'(m_done));
        chk("rem",      32'(rem),      32'(m_rem));
        chk("evt_cnt",  32'(evt_cnt),  32'(m_evt));
        chk("wake_hit", 32'(wake_hit), 32'(m_wake));
    endtask

    task automatic model_edge();
        bit ev[4];
        ev[0] = dfe_v; ev[1] = aco_v; ev[2] = aco_l; ev[3] = wake_v;
        m_done = 0;
        if (cfg_valid) begin
            m_evt = 0; m_wake = 0; m_rem = 0;
            if (cfg_op == 0) m_mode = 0;
            else if (cfg_op == 1) m_mode = 1;
            else if (cfg_arg == 0) begin
                m_mode = 1; m_done = 1;
            end else if (cfg_op == 2) begin
                m_mode = 2; m_rem = int'(cfg_arg);
            end else begin
                m_mode = 3; m_tgt = int'(cfg_arg); m_sel = int'(cfg_sel);
            end
        end else begin
            if (wake_v && wake) m_wake = 1;
            if (m_mode == 2) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_mode = 1; m_done = 1; end
            end else if (m_mode == 3 && ev[m_sel]) begin
                if (m_evt + 1 == m_tgt) begin m_mode = 1; m_done = 1; end
                m_evt = (m_evt == MAXCNT) ? MAXCNT : m_evt + 1;
            end
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        #1;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_valid = 0; cfg_op = 0; cfg_sel = 0; cfg_arg = '0;
        dfe_v = 0; aco_v = 0; aco_l = 0; wake_v = 0; wake = 0;
    endtask

    task automatic cmd(input int op, input int arg, input int sel);
        cfg_valid = 1; cfg_op = 2'(op); cfg_arg = W'(arg); cfg_sel = 2'(sel);
        cycle();
        cfg_valid = 0;
    endtask

    initial begin
        idle_inputs();
        en_i  = 1;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1;
        cycle();
        chk("reset_en_pass", 32'(en_o), 32'd1);

        // Halt, then step exactly three cycles
        cmd(1, 0, 0);
        chk("halt_en", 32'(en_o), 32'd0);
        cmd(2, 3, 0);
        chk("step_rem3", 32'(rem), 32'd3);
        chk("step_en1", 32'(en_o), 32'd1);
        cycle();
        chk("step_rem2", 32'(rem), 32'd2);
        cycle();
        chk("step_rem1", 32'(rem), 32'd1);
        cycle();
        chk("step_rem0", 32'(rem), 32'd0);
        chk("step_done", 32'(done), 32'd1);
        chk("step_halt_en", 32'(en_o), 32'd0);
        cycle();
        chk("step_done_once", 32'(done), 32'd0);
        chk("step_halted", 32'(halted), 32'd1);

        // Arm on aco_valid, two non-adjacent events
        cmd(3, 2, 1);
        chk("arm_busy", 32'(busy), 32'd1);
        cycle();
        aco_v = 1; cycle(); aco_v = 0;
        chk("arm_evt1", 32'(evt_cnt), 32'd1);
        dfe_v = 1; cycle(); dfe_v = 0;
        chk("arm_other_evt", 32'(evt_cnt), 32'd1);
        aco_v = 1; cycle(); aco_v = 0;
        chk("arm_evt2", 32'(evt_cnt), 32'd2);
        chk("arm_done", 32'(done), 32'd1);
        chk("arm_halted", 32'(halted), 32'd1);
        cycle();

        // Zero-argument commands complete immediately
        cmd(2, 0, 0);
        chk("step0_done", 32'(done), 32'd1);
        chk("step0_busy", 32'(busy), 32'd0);
        cmd(3, 0, 2);
        chk("arm0_done", 32'(done), 32'd1);
        chk("arm0_busy", 32'(busy), 32'd0);
        cycle();

        // Abort a step mid-way, then on its completion cycle
        cmd(2, 5, 0);
        cycle();
        cycle();
        cmd(0, 0, 0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(en_o), 32'd1);
        cmd(2, 2, 0);
        cycle();
        chk("cw_rem1", 32'(rem), 32'd1);
        cmd(0, 0, 0);
        chk("cw_done", 32'(done), 32'd0);
        chk("cw_busy", 32'(busy), 32'd0);
        cycle();

        // Wake flag in halt: sticky until the next command
        cmd(1, 0, 0);
        wake_v = 1; wake = 1; cycle(); wake_v = 0; wake = 0;
        chk("wake_set", 32'(wake_hit), 32'd1);
        cycle();
        chk("wake_held", 32'(wake_hit), 32'd1);
        wake_v = 1; wake = 1; cmd(0, 0, 0); wake_v = 0; wake = 0;
        chk("wake_cleared", 32'(wake_hit), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_op    = 2'($urandom_range(0, 3));
            cfg_sel   = 2'($urandom_range(0, 3));
            cfg_arg   = W'($urandom_range(0, 6));
            en_i      = 1'($urandom_range(0, 3) != 0);
            dfe_v     = 1'($urandom_range(0, 2) == 0);
            aco_v     = 1'($urandom_range(0, 2) == 0);
            aco_l     = 1'($urandom_range(0, 3) == 0);
            wake_v    = 1'($urandom_range(0, 3) == 0);
            wake      = 1'($urandom_range(0, 1));
            cycle();
        end
        idle_inputs();
        en_i = 1;

        // Asynchronous reset in the middle of an ARM
        cmd(3, 5, 0);
        dfe_v = 1; cycle(); dfe_v = 0;
        wake_v = 1; wake = 1; cycle(); wake_v = 0; wake = 0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("rst_en_pass", 32'(en_o), 32'd1);
        @(posedge clk);
        #1 rst_n = 1;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
